tdm_demux: RTL and testbench

- Receiving end of the team's time-division multiplexed link: the serial word stream built by the N:1 mux chain is split back into NCH parallel channel words.
- Captures one word per slot into a shadow buffer and publishes a complete frame atomically, with a one-cycle frame_valid strobe.
- Sits between the link input register and per-channel consumers.

---
 rtl/tdm_pkg.sv | 17 +
 rtl/tdm_demux_if.sv | 24 ++
 rtl/tdm_slot_ctr.sv | 31 +++
 rtl/tdm_demux.sv | 102 ++++++++++
 tb/tb_tdm_demux.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM receive (demux) path.
package tdm_pkg;

  localparam int DEFAULT_NCH = 4;
  localparam int DEFAULT_W   = 8;
  localparam int SLOT_W      = $clog2(DEFAULT_NCH);

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } tdm_state_t;

  function automatic int slot_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Link-side slot stream plus the published-frame outputs of the demux.
interface tdm_demux_if #(
  parameter int NCH = tdm_pkg::DEFAULT_NCH,
  parameter int W   = tdm_pkg::DEFAULT_W
);
  logic [W-1:0]             din;
  logic                     din_valid;
  logic                     sof;
  logic [NCH*W-1:0]         ch_data;
  logic                     frame_valid;
  logic                     frame_err;
  logic [$clog2(NCH)-1:0]   slot_idx;
  logic                     busy;

  modport master (
    output din, din_valid, sof,
    input  ch_data, frame_valid, frame_err, slot_idx, busy
  );

  modport slave (
    input  din, din_valid, sof,
    output ch_data, frame_valid, frame_err, slot_idx, busy
  );
endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot counter: load-to-1 on start of frame, increment per slot, clear on frame end.
module tdm_slot_ctr #(
  parameter int NCH = tdm_pkg::DEFAULT_NCH,
  parameter int SW  = tdm_pkg::slot_width(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  input  logic          clr,
  output logic [SW-1:0] count,
  output logic          last
);
  logic [SW-1:0] count_reg;

  // load wins: a start of frame always restarts the count at slot 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= SW'(1);
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + SW'(1);
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == SW'(NCH - 1));
endmodule

// File: rtl/tdm_demux.sv
// TDM demux: collects NCH slot words into a shadow buffer and publishes whole frames atomically.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NCH = DEFAULT_NCH,
  parameter int W   = DEFAULT_W
) (
  input logic          clk,
  input logic          rst_n,
  tdm_demux_if.slave   bus
);
  localparam int SW = slot_width(NCH);

  tdm_state_t           state_reg;
  logic [W-1:0]         shadow_reg [NCH-1];
  logic [NCH*W-1:0]     ch_data_reg;
  logic [NCH*W-1:0]     frame_next;
  logic                 frame_valid_reg;
  logic                 frame_err_reg;
  logic [SW-1:0]        count;
  logic                 last;
  logic                 ctr_load;
  logic                 ctr_inc;
  logic                 ctr_clr;
  logic                 slot_word;

  assign slot_word = bus.din_valid && !bus.sof && (state_reg == RECV);

  always_comb begin
    ctr_load = 1'b0;
    ctr_inc  = 1'b0;
    ctr_clr  = 1'b0;
    if (bus.din_valid && bus.sof) begin
      ctr_load = 1'b1;
    end else if (slot_word) begin
      ctr_clr = last;
      ctr_inc = !last;
    end
  end

  tdm_slot_ctr #(.NCH(NCH), .SW(SW)) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ctr_load),
    .inc   (ctr_inc),
    .clr   (ctr_clr),
    .count (count),
    .last  (last)
  );

  // The last slot never needs storage: it goes straight from din into ch_data.
  for (genvar gi = 0; gi < NCH - 1; gi++) begin : g_shadow
    logic wr;
    assign wr = (gi == 0) ? (bus.din_valid && bus.sof)
                          : (slot_word && (count == SW'(gi)));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_reg[gi] <= '0;
      end else if (wr) begin
        shadow_reg[gi] <= bus.din;
      end
    end
    assign frame_next[gi*W +: W] = shadow_reg[gi];
  end
  assign frame_next[(NCH-1)*W +: W] = bus.din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= HUNT;
      ch_data_reg     <= '0;
      frame_valid_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      frame_valid_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      case (state_reg)
        HUNT: begin
          if (bus.din_valid && bus.sof) begin
            state_reg <= RECV;
          end
        end
        RECV: begin
          if (bus.din_valid && bus.sof) begin
            // premature start: drop the partial frame, keep receiving the new one
            frame_err_reg <= 1'b1;
          end else if (bus.din_valid && last) begin
            ch_data_reg     <= frame_next;
            frame_valid_reg <= 1'b1;
            state_reg       <= HUNT;
          end
        end
        default: state_reg <= HUNT;
      endcase
    end
  end

  assign bus.ch_data     = ch_data_reg;
  assign bus.frame_valid = frame_valid_reg;
  assign bus.frame_err   = frame_err_reg;
  assign bus.slot_idx    = count;
  assign bus.busy        = (state_reg == RECV);
endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (NCH=4, W=8): scoreboarded frames plus inline cycle checks.
module tb_tdm_demux;
  localparam int NCH = 4;
  localparam int W   = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   fv_cnt;
  int   err_cnt;
  int   both_cnt;
  logic [NCH*W-1:0] exp_q [$];
  logic [NCH*W-1:0] obs_q [$];

  tdm_demux_if #(.NCH(NCH), .W(W)) bus ();

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive monitor: records every published frame and pulse count.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_valid === 1'b1) begin
        fv_cnt++;
        obs_q.push_back(bus.ch_data);
      end
      if (bus.frame_err === 1'b1) err_cnt++;
      if (bus.frame_valid === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
    end
  end

  // Presents one input cycle and returns #1 after the edge that sampled it.
  task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
    bus.din_valid = v;
    bus.sof       = s;
    bus.din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    logic [NCH*W-1:0] e;
    logic [NCH*W-1:0] o;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_frame_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s_scoreboard: got %h required %h", name, o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    bus.din_valid = 1'b0; bus.sof = 1'b0; bus.din = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.ch_data !== '0) begin n_fail++; $display("FAIL reset_ch_data: got %h required 0", bus.ch_data); end
    n_checks++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid: got %b required 0", bus.frame_valid); end
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b required 0", bus.frame_err); end
    n_checks++; if (bus.busy !== 1'b0 || bus.slot_idx !== '0) begin n_fail++; $display("FAIL reset_busy_idx: got busy=%b idx=%0d required 0/0", bus.busy, bus.slot_idx); end
    $display("test_reset: done");
  endtask

  task automatic test_nominal();
    int fv0 = fv_cnt;
    int er0 = err_cnt;
    drive(1, 1, 8'h11);
    n_checks++; if (bus.busy !== 1'b1 || bus.slot_idx !== 2'd1) begin n_fail++; $display("FAIL nom_after_sof: got busy=%b idx=%0d required 1/1", bus.busy, bus.slot_idx); end
    drive(1, 0, 8'h22);
    drive(1, 0, 8'h33);
    n_checks++; if (bus.frame_valid !== 1'b0 || bus.slot_idx !== 2'd3) begin n_fail++; $display("FAIL nom_pre_last: got fv=%b idx=%0d required 0/3", bus.frame_valid, bus.slot_idx); end
    exp_q.push_back(32'h44332211);
    drive(1, 0, 8'h44);
    n_checks++; if (bus.frame_valid !== 1'b1 || bus.ch_data !== 32'h44332211) begin n_fail++; $display("FAIL nom_publish: got fv=%b data=%h required 1/44332211", bus.frame_valid, bus.ch_data); end
    n_checks++; if (bus.busy !== 1'b0 || bus.slot_idx !== 2'd0) begin n_fail++; $display("FAIL nom_busy_fall: got busy=%b idx=%0d required 0/0", bus.busy, bus.slot_idx); end
    drive(0, 0, 8'h00);
    n_checks++; if (bus.frame_valid !== 1'b0 || bus.ch_data !== 32'h44332211) begin n_fail++; $display("FAIL nom_pulse_width: got fv=%b data=%h required 0/44332211", bus.frame_valid, bus.ch_data); end
    n_checks++; if (fv_cnt - fv0 != 1 || err_cnt != er0) begin n_fail++; $display("FAIL nom_pulses: got fv=%0d err=%0d required 1/0", fv_cnt - fv0, err_cnt - er0); end
    drain("nom");
    $display("test_nominal: frame 44332211 sent");
  endtask

  task automatic test_back_to_back();
    int fv0 = fv_cnt;
    int er0 = err_cnt;
    for (int i = 0; i < NCH; i++) begin
      if (i == NCH - 1) exp_q.push_back(32'hA3A2A1A0);
      drive(1, (i == 0), 8'hA0 + 8'(i));
      if (i != NCH - 1) begin
        drive(0, 0, 8'hEE);
        n_checks++; if (bus.busy !== 1'b1 || bus.slot_idx !== 2'(i + 1)) begin n_fail++; $display("FAIL b2b_gap_hold: got busy=%b idx=%0d required 1/%0d", bus.busy, bus.slot_idx, i + 1); end
        drive(0, 1, 8'hEF);
      end
    end
    n_checks++; if (bus.frame_valid !== 1'b1 || bus.ch_data !== 32'hA3A2A1A0) begin n_fail++; $display("FAIL b2b_first: got fv=%b data=%h required 1/a3a2a1a0", bus.frame_valid, bus.ch_data); end
    for (int i = 0; i < NCH; i++) begin
      if (i == NCH - 1) exp_q.push_back(32'hB3B2B1B0);
      drive(1, (i == 0), 8'hB0 + 8'(i));
    end
    n_checks++; if (bus.frame_valid !== 1'b1 || bus.ch_data !== 32'hB3B2B1B0) begin n_fail++; $display("FAIL b2b_second: got fv=%b data=%h required 1/b3b2b1b0", bus.frame_valid, bus.ch_data); end
    drive(0, 0, 8'h00);
    n_checks++; if (fv_cnt - fv0 != 2 || err_cnt != er0) begin n_fail++; $display("FAIL b2b_pulses: got fv=%0d err=%0d required 2/0", fv_cnt - fv0, err_cnt - er0); end
    drain("b2b");
    $display("test_back_to_back: frames a3a2a1a0, b3b2b1b0 sent");
  endtask

  task automatic test_premature_sof();
    int er0 = err_cnt;
    drive(1, 1, 8'h01);
    drive(1, 0, 8'h02);
    drive(1, 1, 8'h10);
    n_checks++; if (bus.frame_err !== 1'b1 || bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL pre_err_pulse: got err=%b fv=%b required 1/0", bus.frame_err, bus.frame_valid); end
    n_checks++; if (bus.ch_data !== 32'hB3B2B1B0 || bus.slot_idx !== 2'd1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL pre_hold: got data=%h idx=%0d busy=%b required b3b2b1b0/1/1", bus.ch_data, bus.slot_idx, bus.busy); end
    drive(1, 0, 8'h20);
    n_checks++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL pre_err_width: got %b required 0", bus.frame_err); end
    drive(1, 0, 8'h30);
    exp_q.push_back(32'h40302010);
    drive(1, 0, 8'h40);
    n_checks++; if (bus.frame_valid !== 1'b1 || bus.ch_data !== 32'h40302010) begin n_fail++; $display("FAIL pre_publish: got fv=%b data=%h required 1/40302010", bus.frame_valid, bus.ch_data); end
    drive(0, 0, 8'h00);
    n_checks++; if (err_cnt - er0 != 1) begin n_fail++; $display("FAIL pre_err_count: got %0d required 1", err_cnt - er0); end
    drain("pre");
    $display("test_premature_sof: frame 40302010 after abort");
  endtask

  task automatic test_hunt_discard();
    int fv0 = fv_cnt;
    int er0 = err_cnt;
    drive(1, 0, 8'h55);
    drive(1, 0, 8'h66);
    n_checks++; if (bus.busy !== 1'b0 || bus.slot_idx !== 2'd0 || bus.frame_valid !== 1'b0 || bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL hunt_discard: got busy=%b idx=%0d fv=%b err=%b required 0/0/0/0", bus.busy, bus.slot_idx, bus.frame_valid, bus.frame_err); end
    for (int i = 0; i < NCH; i++) begin
      if (i == NCH - 1) exp_q.push_back(32'h04030201);
      drive(1, (i == 0), 8'h01 + 8'(i));
    end
    n_checks++; if (bus.ch_data !== 32'h04030201) begin n_fail++; $display("FAIL hunt_publish: got %h required 04030201", bus.ch_data); end
    drive(0, 0, 8'h00);
    n_checks++; if (fv_cnt - fv0 != 1 || err_cnt != er0) begin n_fail++; $display("FAIL hunt_pulses: got fv=%0d err=%0d required 1/0", fv_cnt - fv0, err_cnt - er0); end
    drain("hunt");
    $display("test_hunt_discard: frame 04030201 sent");
  endtask

  task automatic test_reset_mid_frame();
    int fv0 = fv_cnt;
    drive(1, 1, 8'h11);
    drive(1, 0, 8'h22);
    bus.din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.slot_idx !== 2'd0 || bus.ch_data !== '0) begin n_fail++; $display("FAIL rmf_async: got busy=%b idx=%0d data=%h required 0/0/0", bus.busy, bus.slot_idx, bus.ch_data); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1, 0, 8'h33);
    drive(1, 0, 8'h44);
    drive(0, 0, 8'h00);
    n_checks++; if (bus.ch_data !== '0 || bus.busy !== 1'b0 || bus.slot_idx !== 2'd0) begin n_fail++; $display("FAIL rmf_after: got data=%h busy=%b idx=%0d required 0/0/0", bus.ch_data, bus.busy, bus.slot_idx); end
    n_checks++; if (fv_cnt != fv0) begin n_fail++; $display("FAIL rmf_no_valid: got %0d pulses required 0", fv_cnt - fv0); end
    drain("rmf");
    $display("test_reset_mid_frame: partial frame dropped");
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    fv_cnt = 0; err_cnt = 0; both_cnt = 0;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_premature_sof();
    test_hunt_discard();
    test_reset_mid_frame();
    n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL exclusive_pulses: got %0d overlaps required 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
